// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, imem handshake, next-PC select
//
// Purpose: fetches one instruction at a time from instruction memory, holds it
// for decode until acknowledged, then computes the next PC from the jump/branch
// feedback sampled on that acknowledge.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   imem_req / imem_addr    read request and byte address (address == pc)
//   imem_ready / imem_rdata read data valid strobe and instruction word
//   inst_valid / inst_ack   instruction presented to decode / consumed by decode
//   instr, op, pc           held instruction, its opcode field, its address
//   Jump, Branch, Zero      control feedback for the acked instruction
//   br_offset, j_index      branch immediate (sign-extended) and jump index
//   retired                 number of acked instructions (wraps)
//   err                     sticky instruction-memory timeout flag
module if_stage #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          IMEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ack,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [31:0] pc,
   input  logic        Jump,
   input  logic        Branch,
   input  logic        Zero,
   input  logic [31:0] br_offset,
   input  logic [25:0] j_index,
   output logic [31:0] retired,
   output logic        err
);

   localparam int CW = $clog2(IMEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD
   } fetchState_t;

   fetchState_t state;
   fetchState_t nextState;

   logic [31:0]   pcReg;
   logic [31:0]   instrReg;
   logic [31:0]   retiredReg;
   logic          errReg;
   logic [CW-1:0] waitCnt;

   logic [31:0]   pc4;
   logic [31:0]   nextPc;
   logic          fetchDone;
   logic          ackTaken;

   // Handshakes only count in their own state; stray strobes elsewhere are ignored.
   assign fetchDone = (state == REQ)  && imem_ready;
   assign ackTaken  = (state == HOLD) && inst_ack;

   // Next-PC select: jump beats branch; all arithmetic wraps modulo 2^32.
   always_comb begin
      pc4    = pcReg + 32'd4;
      nextPc = pc4;
      if (Jump) begin
         nextPc = {pc4[31:28], j_index, 2'b00};
      end else if (Branch && Zero) begin
         nextPc = pc4 + {br_offset[29:0], 2'b00};
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    nextState = REQ;
         REQ:     if (imem_ready) nextState = HOLD;
         HOLD:    if (inst_ack)   nextState = REQ;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcReg      <= RESET_PC;
         instrReg   <= 32'd0;
         retiredReg <= 32'd0;
         errReg     <= 1'b0;
         waitCnt    <= '0;
      end else begin
         if (fetchDone) begin
            instrReg <= imem_rdata;
         end
         if (ackTaken) begin
            pcReg      <= nextPc;
            retiredReg <= retiredReg + 32'd1;
         end
         // Wait counter saturates at the limit so err stays meaningful for
         // arbitrarily long stalls; err itself is only cleared by reset.
         if ((state == REQ) && !imem_ready) begin
            if (waitCnt != CW'(IMEM_TIMEOUT)) begin
               waitCnt <= waitCnt + CW'(1);
            end
            if (waitCnt >= CW'(IMEM_TIMEOUT - 1)) begin
               errReg <= 1'b1;
            end
         end else begin
            waitCnt <= '0;
         end
      end
   end

   assign imem_req   = (state == REQ);
   assign inst_valid = (state == HOLD);
   assign imem_addr  = pcReg;
   assign pc         = pcReg;
   assign instr      = instrReg;
   assign op         = instrReg[31:26];
   assign retired    = retiredReg;
   assign err        = errReg;

endmodule
